// File: rtl/if_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO of
// {pc, inst} pairs with a combinational, zero-masked head and a flush port.
module if_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     IF_valid,
  input  logic [WIDTH-1:0]         IF_inst,
  input  logic [WIDTH-1:0]         IF_pc,
  output logic                     IF_ready,
  input  logic                     ID_stall,
  input  logic                     ID_flush,
  output logic                     ID_valid,
  output logic [WIDTH-1:0]         ID_inst,
  output logic [WIDTH-1:0]         ID_pc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_queue: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           full, empty;
  logic           push, pop;
  logic [DEPTH-1:0] wr_en;
  logic [EW-1:0]  entry_q [DEPTH];
  logic [EW-1:0]  head;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Handshakes are decided from registered state only, so IF_ready never
  // depends combinationally on any decode-side input.
  assign push = IF_valid && !full;
  assign pop  = !empty && !ID_stall;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Flush and reset both discard any same-cycle push or pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || ID_flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    wr_en = '0;
    if (push && !ID_flush && !i_rst) begin
      wr_en[wr_ptr_reg] = 1'b1;
    end
  end

  // Storage is never reset: stale words are hidden by the empty-masking below.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [EW-1:0] data_reg;
    always_ff @(posedge i_clk) begin
      if (wr_en[gi]) begin
        data_reg <= {IF_pc, IF_inst};
      end
    end
    assign entry_q[gi] = data_reg;
  end

  assign head     = entry_q[rd_ptr_reg];
  assign IF_ready = !full;
  assign ID_valid = !empty;
  assign ID_pc    = empty ? '0 : head[EW-1:WIDTH];
  assign ID_inst  = empty ? '0 : head[WIDTH-1:0];
  assign o_count  = count_reg;

endmodule

// File: tb/tb_if_queue.sv
// Directed bench for if_queue: stimulus pushes expected {pc, inst} into a
// scoreboard queue; a negedge monitor compares head and status every cycle.
module tb_if_queue;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        IF_valid;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc;
  logic        IF_ready;
  logic        ID_stall;
  logic        ID_flush;
  logic        ID_valid;
  logic [31:0] ID_inst;
  logic [31:0] ID_pc;
  logic [2:0]  o_count;

  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 0;

  always #5 clk = ~clk;

  if_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .IF_valid (IF_valid),
    .IF_inst  (IF_inst),
    .IF_pc    (IF_pc),
    .IF_ready (IF_ready),
    .ID_stall (ID_stall),
    .ID_flush (ID_flush),
    .ID_valid (ID_valid),
    .ID_inst  (ID_inst),
    .ID_pc    (ID_pc),
    .o_count  (o_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, then update the reference state for that edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic stall, input logic flush, input logic rst);
    bit do_pop, do_push;
    IF_valid = v;
    IF_pc    = pc;
    IF_inst  = inst;
    ID_stall = stall;
    ID_flush = flush;
    i_rst    = rst;
    @(posedge clk);
    do_pop  = (exp_q.size() != 0) && !stall;
    do_push = v && (exp_q.size() != 4);
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) exp_q.delete(0);
      if (do_push) exp_q.push_back({pc, inst});
    end
    #1;
    $display("cyc t=%0t v=%0b pc=%h stall=%0b flush=%0b rst=%0b -> exp_count=%0d",
             $time, v, pc, stall, flush, rst, exp_q.size());
  endtask

  task automatic idle(input logic stall, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 32'h0, stall, 1'b0, 1'b0);
  endtask

  // Monitor: compares the presented head and status against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count",    {29'd0, o_count}, 32'(exp_q.size()));
        check("if_ready", {31'd0, IF_ready}, {31'd0, exp_q.size() != 4});
        check("id_valid", {31'd0, ID_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
          check("head_pc",   ID_pc,   exp_q[0][63:32]);
          check("head_inst", ID_inst, exp_q[0][31:0]);
        end else begin
          check("empty_pc",   ID_pc,   32'h0);
          check("empty_inst", ID_inst, 32'h0);
        end
      end
    end
  end

  initial begin
    // Reset: two cycles held, then checks in the first cycle after.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    mon_en = 1;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", {31'd0, ID_valid}, 32'h0);
    check("rst_ready", {31'd0, IF_ready}, 32'h1);
    check("rst_count", {29'd0, o_count}, 32'h0);
    idle(1'b0, 1);

    // Fill and drain with a dropped fifth push.
    step(1'b1, 32'h00, 32'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h04, 32'h22, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h08, 32'h33, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h0C, 32'h44, 1'b1, 1'b0, 1'b0);
    check("fill_count", {29'd0, o_count}, 32'h4);
    check("fill_ready", {31'd0, IF_ready}, 32'h0);
    step(1'b1, 32'h10, 32'h55, 1'b1, 1'b0, 1'b0);
    check("drop_count", {29'd0, o_count}, 32'h4);
    check("drop_head",  ID_pc, 32'h00);
    idle(1'b0, 5);
    check("drain_valid", {31'd0, ID_valid}, 32'h0);
    check("drain_pc",    ID_pc, 32'h0);

    // Streaming over 14 entries wraps the pointers three times.
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 32'h100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
      check("stream_count", {29'd0, o_count}, 32'h1);
      check("stream_pc",    ID_pc, 32'h100 + 32'(i * 4));
    end
    idle(1'b0, 2);

    // Flush with a concurrent push; the flushed push must never appear.
    step(1'b1, 32'h14, 32'h66, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h18, 32'h77, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1C, 32'h88, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'h99, 1'b1, 1'b1, 1'b0);
    check("flush_count", {29'd0, o_count}, 32'h0);
    check("flush_valid", {31'd0, ID_valid}, 32'h0);
    check("flush_ready", {31'd0, IF_ready}, 32'h1);
    step(1'b1, 32'h24, 32'hAA, 1'b1, 1'b0, 1'b0);
    check("post_flush_pc", ID_pc, 32'h24);
    idle(1'b0, 2);

    // Stall hold: head stays at 0x40 while pushes fill the queue.
    step(1'b1, 32'h40, 32'hC0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 32'h40 + 32'(i * 4), 32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0);
      check("stall_pc", ID_pc, 32'h40);
    end
    check("stall_full", {29'd0, o_count}, 32'h4);

    // Full with simultaneous pop: push refused, then accepted alongside a pop.
    step(1'b1, 32'h60, 32'hE0, 1'b0, 1'b0, 1'b0);
    check("fullpop_count", {29'd0, o_count}, 32'h3);
    check("fullpop_head",  ID_pc, 32'h44);
    step(1'b1, 32'h64, 32'hE4, 1'b0, 1'b0, 1'b0);
    check("pushpop_count", {29'd0, o_count}, 32'h3);
    check("pushpop_head",  ID_pc, 32'h48);
    step(1'b1, 32'h68, 32'hE8, 1'b1, 1'b0, 1'b0);
    check("refill_count", {29'd0, o_count}, 32'h4);

    // Reset mid-stream while full, with a concurrent push.
    step(1'b1, 32'h70, 32'hF0, 1'b0, 1'b0, 1'b1);
    check("midrst_count", {29'd0, o_count}, 32'h0);
    check("midrst_valid", {31'd0, ID_valid}, 32'h0);
    check("midrst_pc",    ID_pc, 32'h0);
    step(1'b1, 32'h80, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    check("midrst_head", ID_pc, 32'h80);
    idle(1'b0, 3);

    @(negedge clk);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter WIDTH, default 32, instruction and PC width in bits.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 IF_valid  input  1  fetch stage presents an instruction this cycle.
REQ-006 IF_inst  input  WIDTH  fetched instruction word.
REQ-007 IF_pc  input  WIDTH  PC of the fetched instruction.
REQ-008 IF_ready  output  1  queue can accept an entry this cycle.
REQ-009 ID_stall  input  1  decode cannot consume the head entry this cycle.
REQ-010 ID_flush  input  1  discard all queued entries (branch or jump redirect).
REQ-011 ID_valid  output  1  head entry is valid.
REQ-012 ID_inst  output  WIDTH  head instruction; zero when ID_valid=0.
REQ-013 ID_pc  output  WIDTH  head PC; zero when ID_valid=0.
REQ-014 o_count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Function
REQ-015 The block SHALL be a DEPTH-entry circular FIFO of {pc, inst} pairs, with a read pointer and a write pointer of $clog2(DEPTH) bits each, and a count register.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or skipped entry.
REQ-017 IF_ready SHALL be (count != DEPTH); it SHALL NOT depend combinationally on ID_stall, ID_flush or IF_valid.
REQ-018 Push occurs when IF_valid=1 and IF_ready=1: the entry is written at the write pointer and the write pointer increments.
REQ-019 Pop occurs when ID_valid=1 and ID_stall=0: the read pointer increments.
REQ-020 ID_valid SHALL be (count != 0). ID_inst and ID_pc SHALL be the head entry when ID_valid=1, and all-zero otherwise.
REQ-021 Latency: an entry pushed at edge N SHALL appear at the head, with no bypass, no earlier than the cycle after edge N.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including at count=DEPTH-1 and count=1.
REQ-023 When full, IF_valid is ignored; the entry is not written and no state changes from the push side.
REQ-024 When empty, ID_stall has no effect; no pointer moves from the pop side.
REQ-025 When ID_stall=1 with ID_valid=1, the head outputs SHALL hold stable until the pop occurs.
REQ-026 ID_flush=1 at an edge SHALL set count to 0 and both pointers to 0, and SHALL discard any push or pop in the same cycle; ID_valid=0 in the following cycle.
REQ-027 The cycle after a flush SHALL accept a push normally (IF_ready=1).
REQ-028 o_count SHALL equal count at all times.
REQ-029 Storage contents need no reset; only pointers and count reset. Stale data SHALL never be visible, because outputs are zeroed when empty.

Reset
REQ-030 i_rst=1 at a rising edge SHALL set count=0, read pointer=0 and write pointer=0, overriding ID_flush, pushes and pops.
REQ-031 During reset and in the first cycle after it: ID_valid=0, ID_inst=0, ID_pc=0, IF_ready=1, o_count=0.
REQ-032 Reset asserted mid-operation with the queue full SHALL empty the queue in one edge, and no pre-reset entry SHALL later appear.

Verification (WIDTH=32, DEPTH=4)
REQ-033 Fill and drain:
- Stimulus: ID_stall=1; push pc 0x00, 0x04, 0x08, 0x0C with inst 0x11..0x44.
- Response: o_count=4 and IF_ready=0. A fifth push is dropped.
- Then ID_stall=0: outputs 0x00, 0x04, 0x08, 0x0C in order on consecutive cycles, then ID_valid=0 and outputs zero.
REQ-034 Streaming: IF_valid=1 continuously with ID_stall=0 from empty; after the first cycle, ID_valid stays 1, o_count stays 1, and the PCs emerge in push order with no drops over more than 12 entries (pointer wrap exercised at least 3 times).
REQ-035 Flush with concurrent push: queue holds 3 entries; assert ID_flush and IF_valid (pc 0x20) in the same cycle. Next cycle o_count=0 and ID_valid=0; pc 0x20 never appears. A push of pc 0x24 the following cycle appears at the head.
REQ-036 Stall hold: head pc 0x40; hold ID_stall=1 for 5 cycles. ID_pc stays 0x40 throughout, and pushes continue until o_count=4.
REQ-037 Full with simultaneous pop: count=4, ID_stall=0, IF_valid=1. The push is refused (IF_ready=0) and count becomes 3. The next cycle the push is accepted with a simultaneous pop, and count stays 3.
REQ-038 Reset mid-stream: queue full, i_rst=1 for one cycle together with ID_flush=0 and IF_valid=1. Afterwards o_count=0, ID_valid=0 and ID_pc=0, and the first new push appears as the head.
